// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, default timeout and initiator FSM states.
package wb_pkg;

  localparam int WB_ADR_W           = 32;
  localparam int WB_DAT_W           = 32;
  localparam int WB_SEL_W           = 4;
  localparam int WB_TIMEOUT_CYCLES  = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_initiator_timer.sv
// Bus-cycle timeout counter: counts no-ACK cycles and flags the last allowed one.
module wb_initiator_timer
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES,
  parameter int TIMEOUT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST_COUNT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] count_r;

  assign expired = (count_r == LAST_COUNT);

  // Counter holds at its last value so it can never wrap past the compare point.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {TIMEOUT_W{1'b0}};
    end else if (clear) begin
      count_r <= {TIMEOUT_W{1'b0}};
    end else if (enable && !expired) begin
      count_r <= count_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic single-beat initiator: valid/ready command in, one bus cycle,
// valid/ready response out, with a timeout guaranteeing one response per command.
module wb_initiator
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES,
  parameter int TIMEOUT_W      = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [WB_ADR_W-1:0] cmd_adr,
  input  logic [WB_DAT_W-1:0] cmd_dat,
  input  logic [WB_SEL_W-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_dat,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i
);

  wb_state_e state_r;
  logic      accept_s;
  logic      timer_en_s;
  logic      expired_s;

  assign accept_s   = (state_r == IDLE) && cmd_valid && cmd_ready;
  assign timer_en_s = (state_r == BUS) && !wbm_ack_i;

  wb_initiator_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_timer (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (accept_s),
    .enable  (timer_en_s),
    .expired (expired_s)
  );

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r   <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dat   <= {WB_DAT_W{1'b0}};
      rsp_err   <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= {WB_SEL_W{1'b0}};
      wbm_adr_o <= {WB_ADR_W{1'b0}};
      wbm_dat_o <= {WB_DAT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_sel_o <= cmd_sel;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            cmd_ready <= 1'b0;
            state_r   <= BUS;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        BUS: begin
          // ACK takes priority over a coincident timeout.
          if (wbm_ack_i) begin
            rsp_dat   <= wbm_we_o ? {WB_DAT_W{1'b0}} : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            state_r   <= RESP;
          end else if (expired_s) begin
            rsp_dat   <= {WB_DAT_W{1'b0}};
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            state_r   <= RESP;
          end else begin
            state_r   <= BUS;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r   <= RESP;
          end
        end
        default: begin
          state_r   <= IDLE;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed self-checking bench for wb_initiator (TIMEOUT_CYCLES = 8).
module tb_wb_initiator;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  int tests = 0;
  int fails = 0;

  wb_initiator #(
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_W      (16)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Issues one command and plays a slave that ACKs in STB cycle ack_at (0 = never).
  task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int ack_at, input logic [31:0] rdat,
                         output int stb_cycles);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    tick();
    cmd_valid = 1'b0;
    stb_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!wbm_stb_o) break;
      stb_cycles++;
      wbm_ack_i = (stb_cycles == ack_at);
      wbm_dat_i = wbm_ack_i ? rdat : 32'h0;
      tick();
    end
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    tick(); tick();
    tests++;
    if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
    tests++;
    if ({rsp_valid, rsp_dat, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== 104'h0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0",
        {rsp_valid, rsp_dat, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o});
    end
    wb_rst_i = 1'b0;
    tick();
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0004; cmd_dat = 32'hA5A5_1234; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    tests++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b111) begin fails++; $display("FAIL wr_ctrl: got %b expected 111", {wbm_cyc_o, wbm_stb_o, wbm_we_o}); end
    tests++;
    if (wbm_adr_o !== 32'h3000_0004) begin fails++; $display("FAIL wr_adr: got %h expected 30000004", wbm_adr_o); end
    tests++;
    if (wbm_dat_o !== 32'hA5A5_1234) begin fails++; $display("FAIL wr_dat: got %h expected a5a51234", wbm_dat_o); end
    tests++;
    if (wbm_sel_o !== 4'hF) begin fails++; $display("FAIL wr_sel: got %h expected f", wbm_sel_o); end
    tests++;
    if ({cmd_ready, rsp_valid} !== 2'b00) begin fails++; $display("FAIL wr_bus_handshake: got %b expected 00", {cmd_ready, rsp_valid}); end
    wbm_ack_i = 1'b1; wbm_dat_i = 32'hFFFF_FFFF;
    tick();
    wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    tests++;
    if ({wbm_cyc_o, wbm_stb_o} !== 2'b00) begin fails++; $display("FAIL wr_cyc_drop: got %b expected 00", {wbm_cyc_o, wbm_stb_o}); end
    tests++;
    if ({rsp_valid, rsp_err} !== 2'b10) begin fails++; $display("FAIL wr_rsp: got valid/err %b expected 10", {rsp_valid, rsp_err}); end
    tests++;
    if (rsp_dat !== 32'h0) begin fails++; $display("FAIL wr_rsp_dat: got %h expected 0", rsp_dat); end
    tests++;
    if (wbm_adr_o !== 32'h3000_0004) begin fails++; $display("FAIL wr_adr_hold: got %h expected 30000004", wbm_adr_o); end
    take_rsp();
    tests++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin fails++; $display("FAIL wr_rsp_done: got valid/ready %b expected 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_read_wait();
    int n;
    run_cmd(1'b0, 32'h3000_0008, 32'h1111_2222, 4'hF, 4, 32'hDEAD_BEEF, n);
    tests++;
    if (n !== 4) begin fails++; $display("FAIL rd_stb_cycles: got %0d expected 4", n); end
    tests++;
    if ({rsp_valid, rsp_err} !== 2'b10) begin fails++; $display("FAIL rd_rsp: got valid/err %b expected 10", {rsp_valid, rsp_err}); end
    tests++;
    if (rsp_dat !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_rsp_dat: got %h expected deadbeef", rsp_dat); end
    take_rsp();
  endtask

  task automatic test_timeout();
    int n;
    run_cmd(1'b0, 32'h3000_000C, 32'h0, 4'h3, 0, 32'h0, n);
    tests++;
    if (n !== 8) begin fails++; $display("FAIL to_stb_cycles: got %0d expected 8", n); end
    tests++;
    if ({rsp_valid, rsp_err} !== 2'b11) begin fails++; $display("FAIL to_rsp: got valid/err %b expected 11", {rsp_valid, rsp_err}); end
    tests++;
    if (rsp_dat !== 32'h0) begin fails++; $display("FAIL to_rsp_dat: got %h expected 0", rsp_dat); end
    take_rsp();
  endtask

  task automatic test_ack_on_timeout();
    int n;
    run_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, 8, 32'h1234_5678, n);
    tests++;
    if (n !== 8) begin fails++; $display("FAIL ackto_stb_cycles: got %0d expected 8", n); end
    tests++;
    if ({rsp_valid, rsp_err} !== 2'b10) begin fails++; $display("FAIL ackto_rsp: got valid/err %b expected 10", {rsp_valid, rsp_err}); end
    tests++;
    if (rsp_dat !== 32'h1234_5678) begin fails++; $display("FAIL ackto_rsp_dat: got %h expected 12345678", rsp_dat); end
    take_rsp();
  endtask

  task automatic test_backpressure();
    int n;
    run_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1, 32'hCAFE_F00D, n);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0044; cmd_dat = 32'h0BAD_CAFE; cmd_sel = 4'h1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({cmd_ready, rsp_valid, rsp_err, wbm_cyc_o} !== 4'b0100) begin
        fails++; $display("FAIL bp_hold_ctrl[%0d]: got %b expected 0100", i, {cmd_ready, rsp_valid, rsp_err, wbm_cyc_o});
      end
      tests++;
      if (rsp_dat !== 32'hCAFE_F00D) begin fails++; $display("FAIL bp_hold_dat[%0d]: got %h expected cafef00d", i, rsp_dat); end
      tick();
    end
    take_rsp();
    tests++;
    if ({rsp_valid, cmd_ready, wbm_cyc_o} !== 3'b010) begin fails++; $display("FAIL bp_after_rsp: got %b expected 010", {rsp_valid, cmd_ready, wbm_cyc_o}); end
    tick();
    cmd_valid = 1'b0;
    tests++;
    if ({wbm_cyc_o, wbm_we_o, wbm_adr_o} !== {2'b11, 32'h3000_0044}) begin
      fails++; $display("FAIL bp_second_accept: got cyc/we %b adr %h expected 11 30000044", {wbm_cyc_o, wbm_we_o}, wbm_adr_o);
    end
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    tests++;
    if ({rsp_valid, rsp_err, rsp_dat} !== {2'b10, 32'h0}) begin fails++; $display("FAIL bp_second_rsp: got %h expected 200000000", {rsp_valid, rsp_err, rsp_dat}); end
    take_rsp();
  endtask

  task automatic test_reset_mid_bus();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0030; cmd_dat = 32'h5555_AAAA; cmd_sel = 4'hC;
    tick();
    cmd_valid = 1'b0;
    tick();
    tests++;
    if ({wbm_cyc_o, wbm_stb_o} !== 2'b11) begin fails++; $display("FAIL rst_wait_state: got %b expected 11", {wbm_cyc_o, wbm_stb_o}); end
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    tests++;
    if ({cmd_ready, rsp_valid, rsp_dat, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== 105'h0) begin
      fails++; $display("FAIL rst_mid_outputs: got %h expected 0",
        {cmd_ready, rsp_valid, rsp_dat, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o});
    end
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({rsp_valid, wbm_cyc_o, rsp_dat} !== 34'h0) begin fails++; $display("FAIL stray_ack[%0d]: got %h expected 0", i, {rsp_valid, wbm_cyc_o, rsp_dat}); end
    end
    wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b expected 1", cmd_ready); end
  endtask

  initial begin
    wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0;
    cmd_sel = 4'h0; rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_timeout();
    test_ack_on_timeout();
    test_backpressure();
    test_reset_mid_bus();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_initiator.md
# wb_initiator

Wishbone classic (B4, non-pipelined) initiator that turns single-beat read/write commands from a valid/ready request port into bus cycles and returns the result on a valid/ready response port. It is the initiator-side counterpart of the user-area Wishbone slave path in `digitalcore_macro`. It serves two users: the debug command path that reaches the ring-oscillator control registers without the management SoC, and the verification bench as a reusable bus driver. A programmable timeout guarantees that every accepted command produces exactly one response.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: number of bus cycles with STB high and no ACK before the transfer is abandoned; legal range 1..65535.
- TIMEOUT_W, 16: width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2^TIMEOUT_W.

Ports (clock and reset first):
- wb_clk_i  in  1  sole clock; all logic is on its rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  32  byte address, driven to the bus unmodified.
- cmd_dat  in  32  write data.
- cmd_sel  in  4  byte selects.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when both rsp_valid and rsp_ready are high.
- rsp_dat  out  32  read data; 0 for writes and for timeouts.
- rsp_err  out  1  1 = timeout, no ACK received.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone controls.
- wbm_sel_o  out  4;  wbm_adr_o  out  32;  wbm_dat_o  out  32.
- wbm_ack_i  in  1;  wbm_dat_i  in  32.

## Operation
- All outputs are registered.
- FSM states:
  - IDLE → BUS on command accept.
  - BUS → RESP on ACK or on timeout.
  - RESP → IDLE on response accept.
- IDLE:
  - cmd_ready = 1.
  - On accept, cmd_we, cmd_adr, cmd_dat and cmd_sel are captured into wbm_we_o, wbm_adr_o, wbm_dat_o and wbm_sel_o.
  - The timeout counter is cleared.
- BUS:
  - wbm_cyc_o = wbm_stb_o = 1.
  - The counter increments on every cycle in which wbm_ack_i = 0.
  - If wbm_ack_i = 1: capture rsp_dat = wbm_dat_i for reads (0 for writes), set rsp_err = 0, drop CYC/STB, go to RESP.
  - Else, if the counter equals TIMEOUT_CYCLES-1: set rsp_dat = 0, rsp_err = 1, drop CYC/STB, go to RESP.
  - If ACK arrives in the same cycle as the timeout, ACK wins.
- RESP:
  - rsp_valid = 1; rsp_dat and rsp_err are held stable until the response is accepted.
  - cmd_ready = 0, so there is no command overlap; at most one transaction is outstanding.
- wbm_ack_i is ignored outside BUS; a stray ACK has no effect.
- wbm_adr_o, wbm_dat_o, wbm_sel_o and wbm_we_o hold their last values after the cycle ends.
- Reset values, for every output: cmd_ready = 0 during reset and 1 on the first cycle after it. All other outputs reset to 0: rsp_valid, rsp_dat, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o.
- Reset mid-transfer: CYC/STB are low from the edge after wb_rst_i is sampled high; a pending response is discarded; the FSM returns to IDLE.

## Timing
- Command accepted at edge N → CYC/STB high from cycle N+1.
- Slave ACK sampled at edge N+1+k (k ≥ 0 wait states):
  - CYC/STB low from cycle N+2+k;
  - rsp_valid high from cycle N+2+k.
- With a zero-wait slave, command-accept to rsp_valid is 2 cycles.
- Back-to-back throughput with rsp_ready tied high is one transaction per 3+k cycles.
  - The response is accepted at the first RESP edge; IDLE lasts one cycle before the next accept.
- Timeout: STB is high for exactly TIMEOUT_CYCLES cycles; rsp_valid rises the following cycle.
- Counter width rule: TIMEOUT_W bits, compared for equality; the counter never wraps.

## Structure
- Shared package `wb_pkg`, holding:
  - the FSM state enum (IDLE, BUS, RESP);
  - the default TIMEOUT_CYCLES;
  - the Wishbone width constants (ADR 32, DAT 32, SEL 4).
- The digitalcore slave uses the same width constants.
- One sub-module: `wb_initiator_timer`.
  - Inputs: clear and enable.
  - Output: expired.
  - Contains the TIMEOUT_W counter and its comparison.
- Everything else stays flat in `wb_initiator`.

## Test plan
- Write, zero-wait slave:
  - Stimulus: cmd adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF, we=1; slave ACKs in the first STB cycle.
  - Response: the bus shows those exact values for one cycle; rsp_valid 2 cycles after accept with rsp_err=0, rsp_dat=0.
- Read, 3 wait states:
  - Stimulus: slave returns 0xDEAD_BEEF.
  - Response: STB high for 4 cycles; rsp_dat=0xDEAD_BEEF, rsp_err=0.
- Timeout with TIMEOUT_CYCLES=8, no ACK:
  - Response: STB high for exactly 8 cycles; rsp_err=1, rsp_dat=0.
- ACK on the timeout cycle (TIMEOUT_CYCLES=8, ACK in STB cycle 8):
  - Response: rsp_err=0 and the data is captured.
- Response backpressure:
  - Stimulus: rsp_ready low for 5 cycles; a second cmd_valid is held high throughout.
  - Response: cmd_ready stays 0 and rsp_* stay stable; the second command is accepted one cycle after the response is accepted.
- Reset mid-BUS, plus a stray ACK:
  - Stimulus: wb_rst_i pulsed for 1 cycle during a wait state.
  - Response: CYC/STB drop on the next edge; no rsp_valid; every output at its reset value; a stray ACK applied afterwards produces no response.
